stage_sequencer: RTL and testbench
==================================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL declare `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL declare `rst_n`, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL declare `run_en`, input, 1 bit: 1 = free-running instruction execution.
REQ-004 SHALL declare `step`, input, 1 bit: single-cycle pulse; advances exactly one instruction while `run_en`=0.
REQ-005 SHALL declare `reload`, input, 1 bit: request to return to program load.
REQ-006 SHALL declare `load_valid`, input, 1 bit: loader word valid.
REQ-007 SHALL declare `load_data`, input, 12 bits: instruction word to store.
REQ-008 SHALL declare `load_last`, input, 1 bit: qualifies the final word of the program.
REQ-009 SHALL declare `load_ready`, output, 1 bit: sequencer accepts a word this cycle.
REQ-010 SHALL declare `pmem_we`, output, 1 bit: program-memory write strobe.
REQ-011 SHALL declare `pmem_addr`, output, 8 bits: program-memory load address.
REQ-012 SHALL declare `pmem_wdata`, output, 12 bits: program-memory write data.
REQ-013 SHALL declare `stage`, output, 2 bits: LOAD=00, FETCH=01, DECODE=10, EXECUTE=11, driven to the control unit.
REQ-014 SHALL declare `core_clr`, output, 1 bit: one-cycle pulse clearing PC/Acc/SR on the LOAD->FETCH transition.
REQ-015 SHALL declare `instr_count`, output, 16 bits: count of executed instructions.

Function
REQ-016 SHALL use a state register whose encoding equals `stage`; `stage` SHALL be driven directly from it with no combinational logic.
REQ-017 In LOAD: `load_ready` = !`reload`. All other states: `load_ready` = 0.
REQ-018 SHALL define a word as accepted when `load_valid` & `load_ready`. Same cycle, combinationally: `pmem_we`=1, `pmem_wdata`=`load_data`, `pmem_addr`=load counter.
REQ-019 The load counter SHALL increment by 1 per accepted word.
REQ-020 Accepting a word with `load_last`=1, or accepting at counter=255, SHALL cause the next state to be FETCH and assert `core_clr` for that next cycle only.
REQ-021 The counter SHALL NOT wrap while in LOAD.
REQ-022 With `load_valid`=0, LOAD SHALL hold indefinitely.
REQ-023 FETCH->DECODE SHALL occur when `run_en`=1, or when a step credit is pending; otherwise the sequencer SHALL hold in FETCH.
REQ-024 A `step` pulse SHALL set a 1-bit step credit. The credit SHALL be consumed on FETCH->DECODE.
REQ-025 `step` while `run_en`=1 SHALL be ignored.
REQ-026 Multiple `step` pulses before consumption SHALL collapse into one credit.
REQ-027 DECODE->EXECUTE and EXECUTE->FETCH SHALL each be unconditional, one cycle.
REQ-028 Steady-state run SHALL be 3 cycles per instruction.
REQ-029 `instr_count` SHALL increment once per cycle in EXECUTE and saturate at 16'hFFFF.
REQ-030 `reload`=1 in any state other than LOAD SHALL force the next state to LOAD. On that transition the sequencer SHALL clear the load counter, step credit, and `instr_count`.
REQ-031 `reload` during EXECUTE SHALL still leave the current EXECUTE cycle intact; the control unit completes that instruction.
REQ-032 `reload`=1 while in LOAD SHALL clear the load counter and block acceptance that cycle; reload has priority over a simultaneous word.
REQ-033 `pmem_addr` SHALL equal the load counter in all states; `pmem_we` SHALL be 0 outside LOAD.

Reset
REQ-034 On `rst_n`=0 at a clock edge, the sequencer SHALL set: state=LOAD, load counter=0, step credit=0, `instr_count`=0, `core_clr`=0.
REQ-035 Resulting outputs after reset: `stage`=00, `load_ready`=1, `pmem_we`=0 (given `load_valid`=0), `pmem_addr`=0.
REQ-036 Reset SHALL take priority over `reload`, `step`, and load handshakes. A reset mid-load SHALL discard progress; already-written memory words are not erased.

Structure
REQ-037 The stage encodings (LOAD/FETCH/DECODE/EXECUTE) SHALL live in a shared package/include used by both stage_sequencer and the control unit, together with the constants PMEM_AW=8 and IW=12.
REQ-038 SHALL contain one sub-module, `sat_counter`: a parameterised width, enable, synchronous clear, saturating up-counter used for `instr_count`.
REQ-039 The load counter SHALL be inline logic.

Verification
REQ-040 Reset, then 4 words 0x801,0x902,0x403,0x000 with `load_last` on the 4th -> `pmem_we` at addr 0..3 with matching data; `stage`=01 and `core_clr`=1 the cycle after; `core_clr`=0 the next.
REQ-041 Load 256 words without `load_last` -> last write at addr 0xFF; `stage`=01 next cycle; no write to addr 0.
REQ-042 `run_en`=1 for 30 cycles after load -> `stage` repeats 01,10,11; `instr_count`=10.
REQ-043 `run_en`=0, `step` pulsed 3 times within 1 cycle-group while in FETCH -> exactly one DECODE/EXECUTE pass; `instr_count`+1; `stage` then holds at 01.
REQ-044 `reload` asserted in DECODE -> next `stage`=00, `instr_count`=0, counter=0; a `load_valid` word in the same cycle as `reload` -> no `pmem_we`.
REQ-045 `rst_n`=0 mid-load after 5 words -> `stage`=00, `pmem_addr`=0; the next accepted word is written to addr 0.

Source files
------------

// File: rtl/stage_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// stage_sequencer_pkg
// Shared definitions for the stage sequencer and the control unit it drives:
// the stage encoding (which is also the sequencer state encoding), the program
// memory geometry and a helper that recognises the final word of a load.
// -----------------------------------------------------------------------------
package stage_sequencer_pkg;

    localparam int PMEM_AW = 8;    // program memory address width
    localparam int IW      = 12;   // instruction word width
    localparam int ICNT_W  = 16;   // executed-instruction counter width

    // Stage encoding seen by the control unit; the sequencer state register
    // uses exactly this encoding so that `stage` is a plain register output.
    typedef enum logic [1:0] {
        STAGE_LOAD    = 2'b00,
        STAGE_FETCH   = 2'b01,
        STAGE_DECODE  = 2'b10,
        STAGE_EXECUTE = 2'b11
    } stage_t;

    localparam logic [PMEM_AW-1:0] PMEM_TOP_ADDR = {PMEM_AW{1'b1}};

    // A load ends either on an explicitly tagged last word or when the word
    // lands in the top memory location (the memory is then full).
    function automatic logic is_final_word(input logic                 last,
                                           input logic [PMEM_AW-1:0]   addr);
        return last | (addr == PMEM_TOP_ADDR);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Parameterised saturating up-counter with enable and synchronous clear.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (count -> 0)
//   clr   : synchronous clear, wins over enable
//   en    : count up by one this cycle unless already at all-ones
//   count : registered count value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Count register: reset, then clear, then saturating increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= {WIDTH{1'b0}};
        end else if (en && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
// Sequences a small processor through program load and the three-stage
// FETCH -> DECODE -> EXECUTE instruction cycle.
//   clk         : clock, all state changes on the rising edge
//   rst_n       : synchronous active-low reset
//   run_en      : free-running execution when 1
//   step        : pulse; grants one instruction while run_en = 0
//   reload      : return to program load (clears load address, credit, count)
//   load_valid  : loader word valid
//   load_data   : instruction word to store
//   load_last   : marks the final word of the program
//   load_ready  : a word is accepted this cycle when load_valid is also 1
//   pmem_we     : program memory write strobe (same cycle as acceptance)
//   pmem_addr   : program memory address (the load counter)
//   pmem_wdata  : program memory write data
//   stage       : current stage, LOAD=00 FETCH=01 DECODE=10 EXECUTE=11
//   core_clr    : one-cycle pulse on entry to FETCH from LOAD
//   instr_count : saturating count of EXECUTE cycles
// -----------------------------------------------------------------------------
module stage_sequencer
    import stage_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_en,
    input  logic               step,
    input  logic               reload,
    input  logic               load_valid,
    input  logic [IW-1:0]      load_data,
    input  logic               load_last,
    output logic               load_ready,
    output logic               pmem_we,
    output logic [PMEM_AW-1:0] pmem_addr,
    output logic [IW-1:0]      pmem_wdata,
    output logic [1:0]         stage,
    output logic               core_clr,
    output logic [ICNT_W-1:0]  instr_count
);

    localparam logic [PMEM_AW-1:0] LOAD_CNT_ONE = {{(PMEM_AW-1){1'b0}}, 1'b1};

    stage_t              state_r;
    stage_t              state_next_s;
    logic [PMEM_AW-1:0]  load_cnt_r;
    logic [PMEM_AW-1:0]  load_cnt_next_s;
    logic                credit_r;
    logic                credit_next_s;
    logic                core_clr_r;
    logic                core_clr_next_s;

    logic                is_load_s;
    logic                load_ready_s;
    logic                accept_s;
    logic                reload_exit_s;
    logic                fetch_adv_s;
    logic                icnt_en_s;

    // Handshake and transition qualifiers derived from the current state.
    always_comb begin
        is_load_s     = (state_r == STAGE_LOAD);
        // Reload in LOAD blocks acceptance so it wins over a simultaneous word.
        load_ready_s  = is_load_s & ~reload;
        accept_s      = load_ready_s & load_valid;
        // Reload outside LOAD aborts execution; EXECUTE still completes its
        // cycle because stage is registered and only the next state changes.
        reload_exit_s = reload & ~is_load_s;
        fetch_adv_s   = (state_r == STAGE_FETCH) & ~reload & (run_en | credit_r);
        icnt_en_s     = (state_r == STAGE_EXECUTE);
    end

    // Next-state logic for the stage FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            STAGE_LOAD: begin
                if (accept_s && is_final_word(load_last, load_cnt_r)) begin
                    state_next_s = STAGE_FETCH;
                end else begin
                    state_next_s = STAGE_LOAD;
                end
            end
            STAGE_FETCH: begin
                if (reload) begin
                    state_next_s = STAGE_LOAD;
                end else if (run_en || credit_r) begin
                    state_next_s = STAGE_DECODE;
                end else begin
                    state_next_s = STAGE_FETCH;
                end
            end
            STAGE_DECODE: begin
                if (reload) begin
                    state_next_s = STAGE_LOAD;
                end else begin
                    state_next_s = STAGE_EXECUTE;
                end
            end
            STAGE_EXECUTE: begin
                if (reload) begin
                    state_next_s = STAGE_LOAD;
                end else begin
                    state_next_s = STAGE_FETCH;
                end
            end
            default: begin
                state_next_s = STAGE_LOAD;
            end
        endcase
    end

    // Load counter: cleared by reload in any state, holds at the top address
    // so it never wraps back onto word 0.
    always_comb begin
        load_cnt_next_s = load_cnt_r;
        if (reload) begin
            load_cnt_next_s = {PMEM_AW{1'b0}};
        end else if (accept_s && (load_cnt_r != PMEM_TOP_ADDR)) begin
            load_cnt_next_s = load_cnt_r + LOAD_CNT_ONE;
        end else begin
            load_cnt_next_s = load_cnt_r;
        end
    end

    // Step credit: consumption on FETCH->DECODE wins over a coincident step,
    // so back-to-back pulses while waiting in FETCH grant a single pass.
    always_comb begin
        credit_next_s = credit_r;
        if (reload_exit_s) begin
            credit_next_s = 1'b0;
        end else if (fetch_adv_s) begin
            credit_next_s = 1'b0;
        end else if (step && !run_en) begin
            credit_next_s = 1'b1;
        end else begin
            credit_next_s = credit_r;
        end
    end

    // core_clr fires in the first FETCH cycle after the load completes.
    always_comb begin
        core_clr_next_s = 1'b0;
        if (accept_s) begin
            core_clr_next_s = is_final_word(load_last, load_cnt_r);
        end else begin
            core_clr_next_s = 1'b0;
        end
    end

    // Sequencer state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= STAGE_LOAD;
            load_cnt_r <= {PMEM_AW{1'b0}};
            credit_r   <= 1'b0;
            core_clr_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            load_cnt_r <= load_cnt_next_s;
            credit_r   <= credit_next_s;
            core_clr_r <= core_clr_next_s;
        end
    end

    sat_counter #(
        .WIDTH (ICNT_W)
    ) u_instr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (reload_exit_s),
        .en    (icnt_en_s),
        .count (instr_count)
    );

    assign stage      = state_r;
    assign load_ready = load_ready_s;
    assign pmem_we    = accept_s;
    assign pmem_addr  = load_cnt_r;
    assign pmem_wdata = accept_s ? load_data : {IW{1'b0}};
    assign core_clr   = core_clr_r;

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
// Self-checking bench: a table of reset/load vectors with fixed expectations,
// hand-written multi-cycle sequences, and randomized stimulus compared every
// cycle against a behavioural model of the sequencer rules.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_en = 1'b0;
    logic        step = 1'b0;
    logic        reload = 1'b0;
    logic        load_valid = 1'b0;
    logic [11:0] load_data = 12'h000;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        pmem_we;
    logic [7:0]  pmem_addr;
    logic [11:0] pmem_wdata;
    logic [1:0]  stage;
    logic        core_clr;
    logic [15:0] instr_count;

    always #5 clk = ~clk;

    stage_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run_en      (run_en),
        .step        (step),
        .reload      (reload),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .pmem_we     (pmem_we),
        .pmem_addr   (pmem_addr),
        .pmem_wdata  (pmem_wdata),
        .stage       (stage),
        .core_clr    (core_clr),
        .instr_count (instr_count)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: phase 0..3 = LOAD/FETCH/DECODE/EXECUTE.
    bit m_valid  = 1'b0;
    int m_phase  = 0;
    int m_cnt    = 0;
    bit m_credit = 1'b0;
    int m_icnt   = 0;
    bit m_cclr   = 1'b0;

    // Outputs sampled mid-cycle by do_cycle.
    logic [1:0]  s_stage;
    logic        s_ready;
    logic        s_we;
    logic [7:0]  s_addr;
    logic [11:0] s_wdata;
    logic        s_cclr;
    logic [15:0] s_icnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, sample and check against the model,
    // then advance the model on the rising edge.
    task automatic do_cycle(input logic rn, input logic run, input logic st, input logic rl,
                            input logic lv, input logic [11:0] ld, input logic ll);
        bit e_ready;
        bit e_we;
        bit nclr;
        @(negedge clk);
        rst_n = rn; run_en = run; step = st; reload = rl;
        load_valid = lv; load_data = ld; load_last = ll;
        #1;
        s_stage = stage; s_ready = load_ready; s_we = pmem_we; s_addr = pmem_addr;
        s_wdata = pmem_wdata; s_cclr = core_clr; s_icnt = instr_count;
        if (m_valid) begin
            e_ready = (m_phase == 0) && !rl;
            e_we    = e_ready && lv;
            check("m_stage", 32'(s_stage), 32'(m_phase));
            check("m_load_ready", 32'(s_ready), 32'(e_ready));
            check("m_pmem_we", 32'(s_we), 32'(e_we));
            check("m_pmem_addr", 32'(s_addr), 32'(m_cnt));
            if (e_we) check("m_pmem_wdata", 32'(s_wdata), 32'(ld));
            check("m_core_clr", 32'(s_cclr), 32'(m_cclr));
            check("m_instr_count", 32'(s_icnt), 32'(m_icnt));
        end
        @(posedge clk);
        if (!rn) begin
            m_valid = 1'b1; m_phase = 0; m_cnt = 0; m_credit = 1'b0; m_icnt = 0; m_cclr = 1'b0;
        end else begin
            nclr = 1'b0;
            if (m_phase == 0) begin
                if (st && !run) m_credit = 1'b1;
                if (rl) begin
                    m_cnt = 0;
                end else if (lv) begin
                    if (ll || m_cnt == 255) begin
                        m_phase = 1;
                        nclr = 1'b1;
                    end
                    if (m_cnt < 255) m_cnt = m_cnt + 1;
                end
            end else if (rl) begin
                m_phase = 0; m_cnt = 0; m_credit = 1'b0; m_icnt = 0;
            end else begin
                if (m_phase == 3 && m_icnt < 65535) m_icnt = m_icnt + 1;
                if (m_phase == 1 && (run || m_credit)) begin
                    m_credit = 1'b0;
                    m_phase = 2;
                end else begin
                    if (st && !run) m_credit = 1'b1;
                    m_phase = (m_phase == 2) ? 3 : 1;
                end
            end
            m_cclr = nclr;
        end
    endtask

    typedef struct {
        logic        rn, run, st, rl, lv;
        logic [11:0] ld;
        logic        ll;
        logic        chk;
        logic [1:0]  e_stage;
        logic        e_ready, e_we;
        logic [7:0]  e_addr;
        logic [11:0] e_wdata;
        logic        e_cclr;
        logic [15:0] e_icnt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic        r_run;
        logic [1:0]  exp43[8];
        logic        stp43[8];

        // Reset, then load 4 words with load_last on the fourth.
        vecs[0] = '{1'b0,1'b0,1'b0,1'b0,1'b0,12'h000,1'b0, 1'b0, 2'd0,1'b0,1'b0,8'h00,12'h000,1'b0,16'd0};
        vecs[1] = '{1'b1,1'b0,1'b0,1'b0,1'b1,12'h801,1'b0, 1'b1, 2'd0,1'b1,1'b1,8'h00,12'h801,1'b0,16'd0};
        vecs[2] = '{1'b1,1'b0,1'b0,1'b0,1'b1,12'h902,1'b0, 1'b1, 2'd0,1'b1,1'b1,8'h01,12'h902,1'b0,16'd0};
        vecs[3] = '{1'b1,1'b0,1'b0,1'b0,1'b1,12'h403,1'b0, 1'b1, 2'd0,1'b1,1'b1,8'h02,12'h403,1'b0,16'd0};
        vecs[4] = '{1'b1,1'b0,1'b0,1'b0,1'b1,12'h000,1'b1, 1'b1, 2'd0,1'b1,1'b1,8'h03,12'h000,1'b0,16'd0};
        vecs[5] = '{1'b1,1'b0,1'b0,1'b0,1'b0,12'h000,1'b0, 1'b1, 2'd1,1'b0,1'b0,8'h04,12'h000,1'b1,16'd0};
        vecs[6] = '{1'b1,1'b0,1'b0,1'b0,1'b0,12'h000,1'b0, 1'b1, 2'd1,1'b0,1'b0,8'h04,12'h000,1'b0,16'd0};

        for (int i = 0; i < 7; i++) begin
            do_cycle(vecs[i].rn, vecs[i].run, vecs[i].st, vecs[i].rl,
                     vecs[i].lv, vecs[i].ld, vecs[i].ll);
            if (vecs[i].chk) begin
                check($sformatf("tbl%0d_stage", i), 32'(s_stage), 32'(vecs[i].e_stage));
                check($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(vecs[i].e_ready));
                check($sformatf("tbl%0d_we", i), 32'(s_we), 32'(vecs[i].e_we));
                check($sformatf("tbl%0d_addr", i), 32'(s_addr), 32'(vecs[i].e_addr));
                if (vecs[i].e_we) check($sformatf("tbl%0d_wdata", i), 32'(s_wdata), 32'(vecs[i].e_wdata));
                check($sformatf("tbl%0d_core_clr", i), 32'(s_cclr), 32'(vecs[i].e_cclr));
                check($sformatf("tbl%0d_icnt", i), 32'(s_icnt), 32'(vecs[i].e_icnt));
            end
        end

        // Free run for 30 cycles: FETCH, DECODE, EXECUTE repeating.
        for (int i = 0; i < 30; i++) begin
            do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
            check("run_stage", 32'(s_stage), 32'(i % 3 + 1));
        end
        #1;
        check("run_icount", 32'(instr_count), 32'd10);
        check("run_end_stage", 32'(stage), 32'd1);

        // Back-to-back step pulses while waiting in FETCH: one pass only.
        exp43 = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1};
        stp43 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b1, 1'b0, stp43[i], 1'b0, 1'b0, 12'h000, 1'b0);
            check($sformatf("step_stage%0d", i), 32'(s_stage), 32'(exp43[i]));
        end
        #1;
        check("step_icount", 32'(instr_count), 32'd11);

        // Reload in DECODE with a simultaneous loader word.
        do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'hABC, 1'b0);
        check("rl_in_decode_stage", 32'(s_stage), 32'd2);
        check("rl_in_decode_we", 32'(s_we), 32'd0);
        #1;
        check("rl_after_stage", 32'(stage), 32'd0);
        check("rl_after_icount", 32'(instr_count), 32'd0);
        check("rl_after_addr", 32'(pmem_addr), 32'd0);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h555, 1'b0);
        check("rl_in_load_we", 32'(s_we), 32'd0);
        check("rl_in_load_ready", 32'(s_ready), 32'd0);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h123, 1'b0);
        check("post_rl_we", 32'(s_we), 32'd1);
        check("post_rl_addr", 32'(s_addr), 32'd0);

        // Reset after five accepted words discards load progress.
        for (int i = 1; i < 5; i++) begin
            do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'(i * 17), 1'b0);
            check("midload_addr", 32'(s_addr), 32'(i));
        end
        do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        #1;
        check("rst_mid_stage", 32'(stage), 32'd0);
        check("rst_mid_addr", 32'(pmem_addr), 32'd0);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h777, 1'b0);
        check("rst_mid_next_we", 32'(s_we), 32'd1);
        check("rst_mid_next_addr", 32'(s_addr), 32'd0);

        // Fill all 256 locations without load_last.
        do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
        for (int i = 0; i < 256; i++) begin
            do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'($urandom), 1'b0);
            check("fill_we", 32'(s_we), 32'd1);
            check("fill_addr", 32'(s_addr), 32'(i));
        end
        #1;
        check("fill_stage", 32'(stage), 32'd1);
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'hFFF, 1'b0);
            check("fill_after_we", 32'(s_we), 32'd0);
            check("fill_after_addr", 32'(s_addr), 32'hFF);
        end

        // Randomized stimulus against the model.
        r_run = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) r_run = ~r_run;
            do_cycle(($urandom_range(0, 299) != 0), r_run,
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
                     ($urandom_range(0, 1) == 0), 12'($urandom),
                     ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
